free_list_nway: RTL



---
 rtl/free_list_nway_pkg.sv | 46 ++++
 rtl/fl_lane_prefix.sv | 20 ++
 rtl/free_list_nway.sv | 122 ++++++++++++
 3 files changed

// File: rtl/free_list_nway_pkg.sv
// rtl/free_list_nway_pkg.sv - shared sizes, tag/pointer types, lane bundles and wrap-bit pointer helpers
package free_list_nway_pkg;

  localparam int NUM_SUPER = 2;
  localparam int NUM_PR    = 64;
  localparam int NUM_ARCH  = 32;
  localparam int NUM_FL    = NUM_PR - NUM_ARCH;
  localparam int ZERO_PR   = 31;
  localparam int PRW       = $clog2(NUM_PR);
  localparam int IDXW      = $clog2(NUM_FL);
  localparam int PTRW      = IDXW + 1;
  localparam int CNTW      = $clog2(NUM_FL + 1);
  localparam int LCW       = $clog2(NUM_SUPER + 1);

  typedef logic [PTRW-1:0] FL_PTR_t;
  typedef logic [PRW-1:0]  PR_t;

  typedef struct packed {
    logic                 en;
    logic [NUM_SUPER-1:0] dest_valid;
  } DISPATCH_t;

  typedef struct packed {
    logic [NUM_SUPER-1:0] en;
    PR_t  [NUM_SUPER-1:0] told;
  } RETIRE_t;

  // NUM_FL need not be a power of two, so the index wraps by compare-and-subtract
  function automatic FL_PTR_t fl_ptr_add(FL_PTR_t p, logic [LCW-1:0] n);
    logic [IDXW:0] sum;
    sum = {1'b0, p[IDXW-1:0]} + {{(IDXW + 1 - LCW){1'b0}}, n};
    if (sum >= (IDXW + 1)'(NUM_FL)) begin
      sum = sum - (IDXW + 1)'(NUM_FL);
      return {~p[IDXW], sum[IDXW-1:0]};
    end
    return {p[IDXW], sum[IDXW-1:0]};
  endfunction

  function automatic logic [CNTW-1:0] fl_dist(FL_PTR_t hi, FL_PTR_t lo);
    int d;
    d = int'(hi[IDXW-1:0]) - int'(lo[IDXW-1:0]);
    if (hi[IDXW] != lo[IDXW]) d = d + NUM_FL;
    return CNTW'(d);
  endfunction

endpackage

// File: rtl/fl_lane_prefix.sv
// rtl/fl_lane_prefix.sv - exclusive prefix popcount across N lanes, plus the total
module fl_lane_prefix #(
  parameter int N  = 2,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         i_bits,
  output logic [N-1:0][CW-1:0] o_pre,
  output logic [CW-1:0]        o_total
);

  always_comb begin
    o_total = '0;
    o_pre   = '0;
    for (int i = 0; i < N; i++) begin
      o_pre[i] = o_total;
      o_total  = o_total + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/free_list_nway.sv
// rtl/free_list_nway.sv - N-way circular free list of physical register tags with checkpoint rollback
// Define FREE_LIST_PARTIAL_EN to let a bundle dispatch partially; otherwise allocation is all-or-nothing.
module free_list_nway
  import free_list_nway_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_en,
  input  logic [NUM_SUPER-1:0]           dest_valid,
  output logic [NUM_SUPER-1:0]           alloc_grant,
  output logic                           alloc_ready,
  output logic [NUM_SUPER-1:0][PRW-1:0]  alloc_pr,
  output logic [NUM_SUPER-1:0][PTRW-1:0] alloc_ptr,
  input  logic [NUM_SUPER-1:0]           retire_en,
  input  logic [NUM_SUPER-1:0][PRW-1:0]  told_pr,
  input  logic                           rollback_en,
  input  logic [PTRW-1:0]                rollback_ptr,
  output logic [CNTW-1:0]                free_count,
  output logic                           empty,
  output logic                           full
);

  PR_t     r_ring [NUM_FL];
  FL_PTR_t r_rd_ptr;
  FL_PTR_t r_wr_ptr;

  DISPATCH_t                     w_disp;
  RETIRE_t                       w_ret;
  logic [NUM_SUPER-1:0]          w_need;
  logic [NUM_SUPER-1:0]          w_free;
  logic                          w_ret_run;
  logic [NUM_SUPER-1:0][LCW-1:0] w_apre;
  logic [NUM_SUPER-1:0][LCW-1:0] w_rpre;
  logic [LCW-1:0]                w_atot;
  logic [LCW-1:0]                w_rtot;
  logic [LCW-1:0]                w_ntake;
  FL_PTR_t [NUM_SUPER-1:0]       w_rd_slot;
  FL_PTR_t [NUM_SUPER-1:0]       w_wr_slot;

  assign w_disp.en         = dispatch_en;
  assign w_disp.dest_valid = dest_valid;
  assign w_ret.en          = retire_en;
  assign w_ret.told        = told_pr;

  assign w_need = {NUM_SUPER{w_disp.en}} & w_disp.dest_valid;

  // A retire lane frees only while every lower lane is also retiring
  always_comb begin
    w_ret_run = 1'b1;
    w_free    = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      w_ret_run = w_ret_run & w_ret.en[i];
      w_free[i] = w_ret_run & (w_ret.told[i] != PR_t'(ZERO_PR));
    end
  end

  fl_lane_prefix #(.N(NUM_SUPER), .CW(LCW)) u_alloc_prefix (
    .i_bits (w_need),
    .o_pre  (w_apre),
    .o_total(w_atot)
  );

  fl_lane_prefix #(.N(NUM_SUPER), .CW(LCW)) u_retire_prefix (
    .i_bits (w_free),
    .o_pre  (w_rpre),
    .o_total(w_rtot)
  );

  assign free_count  = fl_dist(r_wr_ptr, r_rd_ptr);
  assign empty       = (free_count == '0);
  assign full        = (free_count == CNTW'(NUM_FL));
  assign alloc_ready = !rollback_en && (CNTW'(w_atot) <= free_count);

`ifdef FREE_LIST_PARTIAL_EN
  logic w_run_ok;

  always_comb begin
    w_run_ok    = 1'b1;
    alloc_grant = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      w_run_ok       = w_run_ok & (!w_need[i] | (CNTW'(w_apre[i]) + CNTW'(1) <= free_count));
      alloc_grant[i] = dispatch_en & !rollback_en & w_run_ok;
    end
  end
`else
  assign alloc_grant = {NUM_SUPER{dispatch_en & alloc_ready}};
`endif

  always_comb begin
    w_ntake = '0;
    for (int i = 0; i < NUM_SUPER; i++) begin
      w_rd_slot[i] = fl_ptr_add(r_rd_ptr, w_apre[i]);
      w_wr_slot[i] = fl_ptr_add(r_wr_ptr, w_rpre[i]);
      alloc_ptr[i] = fl_ptr_add(r_rd_ptr, w_apre[i] + LCW'(w_need[i]));
      alloc_pr[i]  = (alloc_grant[i] & w_need[i]) ? r_ring[w_rd_slot[i][IDXW-1:0]] : PR_t'(ZERO_PR);
      w_ntake      = w_ntake + LCW'(alloc_grant[i] & w_need[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FL; i++) r_ring[i] <= PR_t'(NUM_ARCH + i);
      r_rd_ptr <= '0;
      r_wr_ptr <= {1'b1, {IDXW{1'b0}}};
    end else begin
      for (int i = 0; i < NUM_SUPER; i++) begin
        if (w_free[i]) r_ring[w_wr_slot[i][IDXW-1:0]] <= w_ret.told[i];
      end
      r_rd_ptr <= rollback_en ? rollback_ptr : fl_ptr_add(r_rd_ptr, w_ntake);
      r_wr_ptr <= fl_ptr_add(r_wr_ptr, w_rtot);
    end
  end

  // Protocol checks: over-freeing, and rolling back outside the in-flight window
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (32'(free_count) + 32'(w_rtot) <= 32'(NUM_FL));
      if (rollback_en) assert (fl_dist(r_rd_ptr, rollback_ptr) <= CNTW'(NUM_FL) - free_count);
    end
  end

endmodule
